// File: rtl/replay_pkg.sv
// Shared types and defaults for the link replay buffer sequencer.
// Pointers carry one extra wrap bit above the buffer address.
package replay_pkg;

    localparam int AW_DEF = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REPLAY  = 2'd1,
        RETRAIN = 2'd2
    } state_e;

    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timeout counter: clear has priority, counts while enabled and
// raises expire when the count reaches TIMEOUT-1 (holds until cleared).
module replay_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/replay_ctrl.sv
// Replay buffer sequencer: owns head/nxt/tail pointers, retires on ack,
// rewinds on nak or timeout, escalates to retrain. Timer under REPLAY_TIMER_EN.
module replay_ctrl
    import replay_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int TIMEOUT    = 64,
    parameter int MAX_REPLAY = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_valid,
    output logic          new_ready,
    output logic          wr_en,
    output logic [AW-1:0] w_addr,
    output logic          rd_en,
    output logic [AW-1:0] r_addr,
    output logic          tx_valid,
    input  logic          ack,
    input  logic          nak,
    input  logic          retrain_done,
    output logic          full,
    output logic          empty,
    output logic          replay_active,
    output logic          retrain,
    output logic [1:0]    dbg_state
);

    localparam int PW = ptr_width(AW);
    localparam int RW = $clog2(MAX_REPLAY) + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [PW-1:0] head_q, head_d, nxt_q, nxt_d, tail_q, tail_d, rend_q, rend_d;
    logic [PW-1:0] nxt_adv;
    logic [RW-1:0] rcnt_q, rcnt_d;
    state_e        state_q, state_d;
    logic          tx_valid_q;
    logic          do_rd, ack_eff, trig, timer_expire;

    // Upstream handshake: a packet transfers in any cycle where new_valid and
    // new_ready are both high; new_ready depends only on registered state.
    assign full      = (head_q - tail_q) == DEPTH;
    assign empty     = head_q == tail_q;
    assign new_ready = !full && (state_q == RUN);
    assign wr_en     = new_valid && new_ready;
    assign w_addr    = head_q[AW-1:0];

    assign do_rd         = (state_q != RETRAIN) && (nxt_q != head_q);
    assign rd_en         = do_rd;
    assign r_addr        = nxt_q[AW-1:0];
    assign tx_valid      = tx_valid_q;
    assign replay_active = state_q == REPLAY;
    assign retrain       = state_q == RETRAIN;
    assign dbg_state     = state_q;

    always_comb begin
        head_d  = head_q + {{AW{1'b0}}, wr_en};
        nxt_adv = nxt_q + {{AW{1'b0}}, do_rd};
        nxt_d   = nxt_adv;
        tail_d  = tail_q;
        rend_d  = rend_q;
        rcnt_d  = rcnt_q;
        state_d = state_q;
        trig    = 1'b0;
        ack_eff = ack && (nxt_q != tail_q);

        if (ack_eff) begin
            tail_d = tail_q + {{AW{1'b0}}, 1'b1};
            rcnt_d = '0;
        end

        case (state_q)
            RUN, REPLAY: begin
                if ((nak || timer_expire) && (nxt_adv != tail_d)) begin
                    trig = 1'b1;
                    if (rcnt_d == RW'(MAX_REPLAY - 1)) begin
                        // Park nxt at the furthest point ever sent so the
                        // post-retrain replay covers everything outstanding.
                        nxt_d   = (state_q == REPLAY) ? rend_q : nxt_adv;
                        state_d = RETRAIN;
                    end else begin
                        rcnt_d  = rcnt_d + RW'(1);
                        nxt_d   = tail_d;
                        state_d = REPLAY;
                        if (state_q == RUN) begin
                            rend_d = nxt_adv;
                        end
                    end
                end else if ((state_q == REPLAY) && (nxt_adv == rend_q)) begin
                    state_d = RUN;
                end
            end
            RETRAIN: begin
                if (retrain_done) begin
                    rcnt_d = '0;
                    if (nxt_q != tail_d) begin
                        rend_d  = nxt_q;
                        nxt_d   = tail_d;
                        state_d = REPLAY;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef REPLAY_TIMER_EN
    logic timer_clr, timer_en;

    assign timer_en  = (nxt_q != tail_q) && (state_q != RETRAIN);
    assign timer_clr = ack_eff || trig || (state_q == RETRAIN);

    replay_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clr),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );
`else
    // Timer compiled out; constant 0 for any legal TIMEOUT.
    assign timer_expire = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            nxt_q      <= '0;
            tail_q     <= '0;
            rend_q     <= '0;
            rcnt_q     <= '0;
            state_q    <= RUN;
            tx_valid_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            nxt_q      <= nxt_d;
            tail_q     <= tail_d;
            rend_q     <= rend_d;
            rcnt_q     <= rcnt_d;
            state_q    <= state_d;
            tx_valid_q <= do_rd;
        end
    end

endmodule
